move_commit: RTL and testbench

Commits one requested chess move into the board store. Accepts a source/destination square pair over a valid/ready handshake, reads both squares through two combinational board read ports, rejects illegal-ownership moves, then performs a two-cycle write (destination = moving piece, source = empty) through the board's single write port. Sits directly upstream of the board store and downstream of the cursor/selection logic; also owns side-to-move.

---
 rtl/chess_pkg.sv | 44 ++++
 rtl/move_commit.sv | 149 ++++++++++++++
 tb/tb_move_commit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/chess_pkg.sv
// chess_pkg: shared piece encoding, board coordinate width and the
// move_commit state encoding.
//   Piece code: bit3 = colour (1 = black), bits[2:0] = piece type.
//   promote_piece(): returns the piece to store on the destination square.
//   A pawn reaching its last rank becomes a queen of the same colour
//   when promotion is enabled.
package chess_pkg;

  localparam int SQ_W       = 3;
  localparam int PC_W       = 4;
  localparam int COLOUR_BIT = 3;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  localparam logic [2:0] EMPTY  = 3'b000;
  localparam logic [2:0] PAWN   = 3'b001;
  localparam logic [2:0] KING   = 3'b010;
  localparam logic [2:0] QUEEN  = 3'b011;
  localparam logic [2:0] KNIGHT = 3'b100;
  localparam logic [2:0] BISHOP = 3'b101;
  localparam logic [2:0] ROOK   = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_WR_DST = 3'd2,
    ST_WR_SRC = 3'd3,
    ST_RESP   = 3'd4
  } mc_state_t;

  // White pawns advance toward rank 0 and black pawns toward rank 7.
  function automatic logic [PC_W-1:0] promote_piece(input logic [PC_W-1:0] pc,
                                                    input logic [SQ_W-1:0] dcol,
                                                    input logic            en);
    logic last_rank;
    last_rank = (pc[COLOUR_BIT] == WHITE) ? (dcol == 3'd0) : (dcol == 3'd7);
    if (en && (pc[2:0] == PAWN) && last_rank)
      promote_piece = {pc[COLOUR_BIT], QUEEN};
    else
      promote_piece = pc;
  endfunction

endpackage

// File: rtl/move_commit.sv
// move_commit: commits one requested move into the board store.
//   Accepts a src/dst square pair on mv_valid/mv_ready, reads both squares
//   through two combinational board read ports, rejects a move when the
//   source is empty, belongs to the side not on move, equals the
//   destination, or would capture a piece of its own colour.  An accepted
//   move writes the destination (with optional promotion) and then clears
//   the source through the single write port, before answering with done
//   or err.  The block also owns side-to-move (turn).
// Ports:
//   Clk, reset (async active-low)
//   mv_valid/mv_ready, src_rol/src_col/dst_rol/dst_col : move request
//   turn_flip        : toggles turn while idle
//   rd_rol1/rd_col1/rd_din1, rd_rol2/rd_col2/rd_din2 : board read ports
//   wren/wrrol/wrcol/wdatain : board write port
//   done/err/captured/king_taken : one-cycle response
//   turn             : side to move (0 = white)
module move_commit
  import chess_pkg::*;
#(
  parameter bit PROMOTE_EN = 1'b1,
  parameter bit AUTO_TURN  = 1'b1
) (
  input  logic            Clk,
  input  logic            reset,
  input  logic            mv_valid,
  output logic            mv_ready,
  input  logic [SQ_W-1:0] src_rol,
  input  logic [SQ_W-1:0] src_col,
  input  logic [SQ_W-1:0] dst_rol,
  input  logic [SQ_W-1:0] dst_col,
  input  logic            turn_flip,
  output logic [SQ_W-1:0] rd_rol1,
  output logic [SQ_W-1:0] rd_col1,
  input  logic [PC_W-1:0] rd_din1,
  output logic [SQ_W-1:0] rd_rol2,
  output logic [SQ_W-1:0] rd_col2,
  input  logic [PC_W-1:0] rd_din2,
  output logic            wren,
  output logic [SQ_W-1:0] wrrol,
  output logic [SQ_W-1:0] wrcol,
  output logic [PC_W-1:0] wdatain,
  output logic            done,
  output logic            err,
  output logic [PC_W-1:0] captured,
  output logic            king_taken,
  output logic            turn
);

  mc_state_t       state, state_nxt;
  logic [SQ_W-1:0] s_rol, s_col, d_rol, d_col;
  logic [PC_W-1:0] src_pc, dst_pc;
  logic            rej, reject;

  // Ownership test on the live read data; only meaningful in ST_CHECK.
  always_comb begin
    reject = 1'b0;
    if (rd_din1[2:0] == EMPTY)                      reject = 1'b1;
    if (rd_din1[COLOUR_BIT] != turn)                reject = 1'b1;
    if ((s_rol == d_rol) && (s_col == d_col))       reject = 1'b1;
    if ((rd_din2[2:0] != EMPTY) &&
        (rd_din2[COLOUR_BIT] == rd_din1[COLOUR_BIT])) reject = 1'b1;
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      s_rol  <= '0;
      s_col  <= '0;
      d_rol  <= '0;
      d_col  <= '0;
      src_pc <= '0;
      dst_pc <= '0;
      rej    <= 1'b0;
      turn   <= WHITE;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          // A flip coincident with a handshake lands before CHECK reads turn.
          if (turn_flip) turn <= ~turn;
          if (mv_valid) begin
            s_rol <= src_rol;
            s_col <= src_col;
            d_rol <= dst_rol;
            d_col <= dst_col;
          end
        end
        ST_CHECK: begin
          rej    <= reject;
          src_pc <= rd_din1;
          dst_pc <= rd_din2;
        end
        ST_RESP: begin
          if (!rej && AUTO_TURN) turn <= ~turn;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    mv_ready   = 1'b0;
    wren       = 1'b0;
    wrrol      = '0;
    wrcol      = '0;
    wdatain    = '0;
    done       = 1'b0;
    err        = 1'b0;
    captured   = '0;
    king_taken = 1'b0;
    case (state)
      ST_IDLE: begin
        mv_ready = 1'b1;
        if (mv_valid) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        state_nxt = reject ? ST_RESP : ST_WR_DST;
      end
      ST_WR_DST: begin
        wren      = 1'b1;
        wrrol     = d_rol;
        wrcol     = d_col;
        wdatain   = promote_piece(src_pc, d_col, PROMOTE_EN);
        state_nxt = ST_WR_SRC;
      end
      ST_WR_SRC: begin
        wren      = 1'b1;
        wrrol     = s_rol;
        wrcol     = s_col;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        done       = !rej;
        err        = rej;
        captured   = rej ? '0 : dst_pc;
        king_taken = !rej && (dst_pc[2:0] == KING);
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rd_rol1 = s_rol;
  assign rd_col1 = s_col;
  assign rd_rol2 = d_rol;
  assign rd_col2 = d_col;

endmodule

// File: tb/tb_move_commit.sv
// tb_move_commit: directed table of moves on a hand-placed board, a reset
// abort sequence, then randomized boards and moves checked against a
// rule-level move model.
module tb_move_commit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mv_valid, mv_ready, turn_flip;
  logic [2:0] src_rol, src_col, dst_rol, dst_col;
  logic [2:0] rd_rol1, rd_col1, rd_rol2, rd_col2;
  logic [3:0] rd_din1, rd_din2;
  logic       wren;
  logic [2:0] wrrol, wrcol;
  logic [3:0] wdatain;
  logic       done, err, king_taken, turn;
  logic [3:0] captured;

  always #5 clk = ~clk;

  move_commit dut (
    .Clk(clk), .reset(rst_n),
    .mv_valid(mv_valid), .mv_ready(mv_ready),
    .src_rol(src_rol), .src_col(src_col), .dst_rol(dst_rol), .dst_col(dst_col),
    .turn_flip(turn_flip),
    .rd_rol1(rd_rol1), .rd_col1(rd_col1), .rd_din1(rd_din1),
    .rd_rol2(rd_rol2), .rd_col2(rd_col2), .rd_din2(rd_din2),
    .wren(wren), .wrrol(wrrol), .wrcol(wrcol), .wdatain(wdatain),
    .done(done), .err(err), .captured(captured), .king_taken(king_taken),
    .turn(turn)
  );

  // Board store emulation: DUT write port plus a bench load/clear port.
  logic [3:0] board [8][8];
  logic       bclr, bld;
  logic [2:0] ld_r, ld_c;
  logic [3:0] ld_d;

  always @(posedge clk) begin
    if (bclr) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) board[r][c] <= 4'h0;
    end else if (bld) begin
      board[ld_r][ld_c] <= ld_d;
    end
    if (wren) board[wrrol][wrcol] <= wdatain;
  end

  assign rd_din1 = board[rd_rol1][rd_col1];
  assign rd_din2 = board[rd_rol2][rd_col2];

  // Reference: expected board and side to move.
  logic [3:0] ref_board [8][8];
  logic       ref_turn;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic int board_diffs();
    int n = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (board[r][c] !== ref_board[r][c]) n++;
    return n;
  endfunction

  task automatic clear_board();
    @(negedge clk); bclr = 1'b1;
    @(posedge clk); #1 bclr = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) ref_board[r][c] = 4'h0;
  endtask

  task automatic load_sq(input logic [2:0] r, input logic [2:0] c, input logic [3:0] p);
    @(negedge clk); bld = 1'b1; ld_r = r; ld_c = c; ld_d = p;
    @(posedge clk); #1 bld = 1'b0;
    ref_board[r][c] = p;
  endtask

  task automatic flip_pulse();
    @(negedge clk); turn_flip = 1'b1;
    @(posedge clk); #1 turn_flip = 1'b0;
    ref_turn = ~ref_turn;
  endtask

  // Rule-level model of one move request against ref_board / ref_turn.
  task automatic ref_apply(input logic [2:0] sr, sc, dr, dc,
                           output logic e_err, output logic [3:0] e_cap, output logic e_king);
    logic [3:0] s, d, p;
    logic ok;
    s = ref_board[sr][sc];
    d = ref_board[dr][dc];
    ok = (s[2:0] != 3'd0) && (s[3] == ref_turn) && !((sr == dr) && (sc == dc)) &&
         !((d[2:0] != 3'd0) && (d[3] == s[3]));
    e_err = !ok; e_cap = 4'h0; e_king = 1'b0;
    if (ok) begin
      p = s;
      if ((s[2:0] == 3'd1) && ((!s[3] && dc == 3'd0) || (s[3] && dc == 3'd7))) p = {s[3], 3'd3};
      ref_board[dr][dc] = p;
      ref_board[sr][sc] = 4'h0;
      ref_turn = ~ref_turn;
      e_cap = d;
      e_king = (d[2:0] == 3'd2);
    end
  endtask

  task automatic do_move(input logic [2:0] sr, sc, dr, dc, input logic fw,
                         output logic g_err, g_done, output logic [3:0] g_cap,
                         output logic g_king, output int lat, output int wn);
    g_err = 0; g_done = 0; g_cap = 0; g_king = 0; lat = 0; wn = 0;
    @(negedge clk);
    chk("ready_idle", mv_ready, 1);
    mv_valid = 1'b1; src_rol = sr; src_col = sc; dst_rol = dr; dst_col = dc;
    turn_flip = fw;
    @(posedge clk); #1 turn_flip = 1'b0;
    // mv_valid stays high through the response to show it is not re-accepted.
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (wren) wn++;
      if (done || err) begin
        g_done = done; g_err = err; g_cap = captured; g_king = king_taken; lat = i;
        break;
      end
    end
    mv_valid = 1'b0;
    @(negedge clk);
    chk("ready_back", mv_ready, 1);
    chk("no_wren_idle", wren, 0);
  endtask

  typedef struct {
    logic [2:0] sr, sc, dr, dc;
    logic       flip_before, flip_with, e_err;
    logic [3:0] e_cap;
    logic       e_king, e_turn;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic ge, gd, gk, ee, ek;
    logic [3:0] gc, ec;
    int lat, wn;

    rst_n = 1'b0; mv_valid = 0; turn_flip = 0; bclr = 0; bld = 0;
    src_rol = 0; src_col = 0; dst_rol = 0; dst_col = 0; ld_r = 0; ld_c = 0; ld_d = 0;
    ref_turn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", mv_ready, 1);
    chk("rst_wren", wren, 0);
    chk("rst_wr", {wrrol, wrcol, wdatain}, 0);
    chk("rst_rd", {rd_rol1, rd_col1, rd_rol2, rd_col2}, 0);
    chk("rst_resp", {done, err, king_taken, captured}, 0);
    chk("rst_turn", turn, 0);
    @(negedge clk); rst_n = 1'b1;

    clear_board();
    load_sq(4, 6, 4'b0001);
    load_sq(0, 1, 4'b1001);
    load_sq(2, 1, 4'b0001);
    load_sq(3, 0, 4'b1110);
    load_sq(5, 5, 4'b1011);
    load_sq(5, 0, 4'b0010);
    load_sq(6, 6, 4'b0110);

    //          sr sc dr dc  fb  fw  err cap    king turn
    tbl[0] = '{3'd4, 3'd6, 3'd4, 3'd4, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1};
    tbl[1] = '{3'd0, 3'd1, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0};
    tbl[2] = '{3'd2, 3'd1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 4'hE, 1'b0, 1'b1};
    tbl[3] = '{3'd5, 3'd5, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b1, 1'b0};
    tbl[4] = '{3'd4, 3'd4, 3'd4, 3'd4, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0};
    tbl[5] = '{3'd4, 3'd4, 3'd6, 3'd6, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0};
    tbl[6] = '{3'd7, 3'd7, 3'd7, 3'd6, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0};
    tbl[7] = '{3'd0, 3'd1, 3'd0, 3'd2, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0};

    for (int t = 0; t < 8; t++) begin
      if (tbl[t].flip_before) flip_pulse();
      if (tbl[t].flip_with) ref_turn = ~ref_turn;
      ref_apply(tbl[t].sr, tbl[t].sc, tbl[t].dr, tbl[t].dc, ee, ec, ek);
      do_move(tbl[t].sr, tbl[t].sc, tbl[t].dr, tbl[t].dc, tbl[t].flip_with, ge, gd, gc, gk, lat, wn);
      chk($sformatf("v%0d_err", t), ge, tbl[t].e_err);
      chk($sformatf("v%0d_done", t), gd, !tbl[t].e_err);
      chk($sformatf("v%0d_cap", t), gc, tbl[t].e_cap);
      chk($sformatf("v%0d_king", t), gk, tbl[t].e_king);
      chk($sformatf("v%0d_turn", t), turn, tbl[t].e_turn);
      chk($sformatf("v%0d_lat", t), lat, tbl[t].e_err ? 2 : 4);
      chk($sformatf("v%0d_wren", t), wn, tbl[t].e_err ? 0 : 2);
      chk($sformatf("v%0d_board", t), board_diffs(), 0);
    end
    chk("promo_sq", board[3][0], 4'b0011);

    // Reset while the destination write is on the port.
    clear_board();
    load_sq(1, 6, {ref_turn, 3'b001});
    @(negedge clk);
    mv_valid = 1'b1; src_rol = 1; src_col = 6; dst_rol = 1; dst_col = 5;
    @(posedge clk); #1 mv_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_wr", wren, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_wren", wren, 0);
    chk("abort_ready", mv_ready, 1);
    chk("abort_turn", turn, 0);
    chk("abort_resp", {done, err}, 0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    ref_turn = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    chk("abort_board", board_diffs(), 0);

    // Randomized boards and moves.
    for (int n = 0; n < 60; n++) begin
      logic [2:0] sr, sc, dr, dc, r, c, ty;
      logic fw;
      clear_board();
      sr = 3'($urandom_range(0, 7)); sc = 3'($urandom_range(0, 7));
      for (int k = 0; k < 6; k++) begin
        r = 3'($urandom_range(0, 7)); c = 3'($urandom_range(0, 7));
        ty = 3'($urandom_range(0, 6));
        load_sq(r, c, (ty == 0) ? 4'h0 : {1'($urandom_range(0, 1)), ty});
        if (k == 0) begin sr = r; sc = c; end
      end
      if ($urandom_range(0, 4) == 0) begin
        dr = sr; dc = sc;
      end else begin
        dr = 3'($urandom_range(0, 7)); dc = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 5) == 0) flip_pulse();
      fw = ($urandom_range(0, 3) == 0);
      if (fw) ref_turn = ~ref_turn;
      ref_apply(sr, sc, dr, dc, ee, ec, ek);
      do_move(sr, sc, dr, dc, fw, ge, gd, gc, gk, lat, wn);
      chk("rnd_err", ge, ee);
      chk("rnd_done", gd, !ee);
      chk("rnd_cap", gc, ec);
      chk("rnd_king", gk, ek);
      chk("rnd_turn", turn, ref_turn);
      chk("rnd_lat", lat, ee ? 2 : 4);
      chk("rnd_wren", wn, ee ? 0 : 2);
      chk("rnd_board", board_diffs(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
